// File: rtl/clk_div_pkg.sv
// Shared constants and state type for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/clk_div_core.sv
// Period counter with registered clk_out/tick decode for a given divisor.
module clk_div_core #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_q,
  input  logic             run_d,
  input  logic [CNT_W-1:0] div_q,
  input  logic [CNT_W-1:0] div_d,
  output logic             wrap,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  // Outputs are decoded from the next count and next divisor so the flops
  // show the decode of the count they sit alongside in the same cycle.
  always_comb begin
    wrap      = run_q && (cnt_q == div_q - ONE);
    cnt_d     = (run_q && run_d && !wrap) ? cnt_q + ONE : '0;
    clk_out_d = run_d && (cnt_d >= div_d - (div_d >> 1));
    tick_d    = run_d && (cnt_d == div_d - ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    clk_out = clk_out_q;
    tick    = tick_q;
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: enable FSM and deferred divisor load
// around a counter core; divisor changes only land on period boundaries.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic             pending,
  output logic             div_err,
  output logic [CNT_W-1:0] cur_div
);

  localparam logic [CNT_W-1:0] DIV_MIN_W = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pending_q, pending_d;
  logic             div_err_q, div_err_d;
  logic             wrap, apply, load_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_div_q  <= DEF_DIV_W;
      pend_div_q <= '0;
      pending_q  <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pending_q  <= pending_d;
      div_err_q  <= div_err_d;
    end
  end

  // Dropping en never cuts a period short: RUN only exits at the wrap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (wrap && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // div_load is a single-cycle strobe with no back-pressure: a legal div_in
  // is always accepted, held pending until the next boundary (last load
  // wins), or applied straight away when the strobe lands on a boundary.
  always_comb begin
    apply      = (state_q == IDLE) || wrap;
    load_ok    = div_load && (div_in >= DIV_MIN_W);
    div_err_d  = div_load && (div_in < DIV_MIN_W);
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pending_d  = pending_q;
    if (apply) begin
      if (load_ok) begin
        cur_div_d = div_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        cur_div_d = pend_div_q;
        pending_d = 1'b0;
      end
    end else if (load_ok) begin
      pend_div_d = div_in;
      pending_d  = 1'b1;
    end
  end

  always_comb begin
    running = (state_q == RUN);
    pending = pending_q;
    div_err = div_err_q;
    cur_div = cur_div_q;
  end

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_q   (state_q == RUN),
    .run_d   (state_d == RUN),
    .div_q   (cur_div_q),
    .div_d   (cur_div_d),
    .wrap    (wrap),
    .clk_out (clk_out),
    .tick    (tick)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: vector table, corner sequences, and random traffic
// against a period-waveform reference model.
module tb_clk_div_prog;

  localparam int W  = 16;
  localparam int W2 = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, div_load = 1'b0;
  logic [W-1:0]  div_in = '0;
  logic          clk_out, tick, running, pending, div_err;
  logic [W-1:0]  cur_div;

  logic          en2 = 1'b0, ld2 = 1'b0;
  logic [W2-1:0] din2 = '0;
  logic          clk_out2, tick2, running2, pending2, div_err2;
  logic [W2-1:0] cur_div2;

  always #5 clk = ~clk;

  clk_div_prog #(.CNT_W(W), .DEF_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_load(div_load), .div_in(div_in),
    .clk_out(clk_out), .tick(tick), .running(running), .pending(pending),
    .div_err(div_err), .cur_div(cur_div)
  );

  clk_div_prog #(.CNT_W(W2), .DEF_DIV(15)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .div_load(ld2), .div_in(din2),
    .clk_out(clk_out2), .tick(tick2), .running(running2), .pending(pending2),
    .div_err(div_err2), .cur_div(cur_div2)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: each running period is a queue of {clk_out, tick}
  // samples built from the divisor; the front entry is the current cycle.
  logic [1:0] exp_q[$];
  bit         m_run, m_pend_v, m_err;
  int         m_div, m_pend;

  function automatic void model_reset();
    exp_q.delete();
    m_run = 0; m_pend_v = 0; m_err = 0; m_div = 4; m_pend = 0;
  endfunction

  function automatic void model_step(input bit e, input bit ld, input int din);
    bit boundary;
    bit ok;
    boundary = !m_run || (exp_q.size() == 1);
    ok = ld && (din >= 2);
    m_err = ld && (din < 2);
    if (boundary) begin
      if (ok) begin
        m_div = din; m_pend_v = 0;
      end else if (m_pend_v) begin
        m_div = m_pend; m_pend_v = 0;
      end
    end else if (ok) begin
      m_pend = din; m_pend_v = 1;
    end
    if (m_run) void'(exp_q.pop_front());
    if (boundary) m_run = e;
    if (m_run && exp_q.size() == 0)
      for (int i = 0; i < m_div; i++)
        exp_q.push_back({(i >= (m_div + 1) / 2) ? 1'b1 : 1'b0, (i == m_div - 1) ? 1'b1 : 1'b0});
  endfunction

  task automatic cycle(input bit e, input bit ld, input logic [W-1:0] din);
    en = e; div_load = ld; div_in = din;
    @(posedge clk);
    model_step(e, ld, int'(din));
    @(negedge clk);
    div_load = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, " clk_out"}, clk_out, m_run ? exp_q[0][1] : 1'b0);
    check({tag, " tick"},    tick,    m_run ? exp_q[0][0] : 1'b0);
    check({tag, " running"}, running, m_run);
    check({tag, " pending"}, pending, m_pend_v);
    check({tag, " div_err"}, div_err, m_err);
    check({tag, " cur_div"}, cur_div, m_div);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 0; div_load = 0; div_in = '0;
    en2 = 0; ld2 = 0; din2 = '0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit en; bit ld; logic [W-1:0] din;
    bit c; bit t; bit r; bit p; bit e; logic [W-1:0] d;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int hi, lo;
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 0, 4};
    tbl[1]  = '{1, 1, 5, 0, 0, 1, 1, 0, 4};
    tbl[2]  = '{1, 0, 0, 1, 0, 1, 1, 0, 4};
    tbl[3]  = '{1, 0, 0, 1, 1, 1, 1, 0, 4};
    tbl[4]  = '{1, 0, 0, 0, 0, 1, 0, 0, 5};
    tbl[5]  = '{1, 0, 0, 0, 0, 1, 0, 0, 5};
    tbl[6]  = '{1, 0, 0, 0, 0, 1, 0, 0, 5};
    tbl[7]  = '{1, 0, 0, 1, 0, 1, 0, 0, 5};
    tbl[8]  = '{1, 0, 0, 1, 1, 1, 0, 0, 5};
    tbl[9]  = '{1, 1, 1, 0, 0, 1, 0, 1, 5};
    tbl[10] = '{1, 1, 0, 0, 0, 1, 0, 1, 5};
    tbl[11] = '{1, 0, 0, 0, 0, 1, 0, 0, 5};

    // Reset values while rst_n is held low
    model_reset();
    @(negedge clk);
    check("rst clk_out", clk_out, 0);
    check("rst tick", tick, 0);
    check("rst running", running, 0);
    check("rst pending", pending, 0);
    check("rst div_err", div_err, 0);
    check("rst cur_div", cur_div, 4);
    check("rst cur_div2", cur_div2, 15);
    do_reset();

    // Default divisor, mid-period load of 5, rejected loads of 1 and 0
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].en, tbl[i].ld, tbl[i].din);
      check($sformatf("vec%0d clk_out", i), clk_out, tbl[i].c);
      check($sformatf("vec%0d tick", i),    tick,    tbl[i].t);
      check($sformatf("vec%0d running", i), running, tbl[i].r);
      check($sformatf("vec%0d pending", i), pending, tbl[i].p);
      check($sformatf("vec%0d div_err", i), div_err, tbl[i].e);
      check($sformatf("vec%0d cur_div", i), cur_div, tbl[i].d);
    end

    // Two loads in one period: only the last one lands at the wrap
    do_reset();
    cycle(1, 0, 0);
    cycle(1, 1, 6);
    cycle(1, 1, 3);
    check("2ld pending", pending, 1);
    check("2ld cur_div hold", cur_div, 4);
    cycle(1, 0, 0);
    check("2ld tick old period", tick, 1);
    cycle(1, 0, 0);
    check("2ld cur_div new", cur_div, 3);
    check("2ld pending clear", pending, 0);
    check("2ld clk_out c0", clk_out, 0);
    cycle(1, 0, 0);
    check("2ld clk_out c1", clk_out, 0);
    cycle(1, 0, 0);
    check("2ld clk_out c2", clk_out, 1);
    check("2ld tick c2", tick, 1);
    check_model("2ld model");

    // en dropped at cnt=1: period completes, then idle, then clean restart
    do_reset();
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    check("stop c2 clk_out", clk_out, 1);
    check("stop c2 running", running, 1);
    cycle(0, 0, 0);
    check("stop c3 tick", tick, 1);
    check("stop c3 clk_out", clk_out, 1);
    cycle(0, 0, 0);
    check("stop idle running", running, 0);
    check("stop idle clk_out", clk_out, 0);
    check("stop idle tick", tick, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 0);
      check($sformatf("restart c%0d tick", k), tick, (k == 3) ? 1 : 0);
      check($sformatf("restart c%0d running", k), running, 1);
    end

    // Asynchronous reset while a load is pending and clk_out is high
    do_reset();
    cycle(1, 0, 0);
    cycle(1, 1, 7);
    cycle(1, 0, 0);
    check("arst pre clk_out", clk_out, 1);
    check("arst pre pending", pending, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst clk_out", clk_out, 0);
    check("arst tick", tick, 0);
    check("arst running", running, 0);
    check("arst pending", pending, 0);
    check("arst cur_div", cur_div, 4);
    check("arst div_err", div_err, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Largest divisor for a 4-bit counter: 15 -> low 8, high 7
    do_reset();
    en2 = 1'b1;
    hi = 0; lo = 0;
    for (int k = 0; k < 30; k++) begin
      cycle(0, 0, 0);
      if (k < 15) begin
        if (clk_out2) hi++; else lo++;
      end
      check($sformatf("d15 c%0d tick", k), tick2, (k % 15 == 14) ? 1 : 0);
    end
    check("d15 high cycles", hi, 7);
    check("d15 low cycles", lo, 8);
    check("d15 cur_div", cur_div2, 15);
    en2 = 1'b0;

    // Random en / load traffic against the reference model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      bit e, ld;
      logic [W-1:0] din;
      e   = ($urandom_range(0, 9) != 0) || (k % 97 < 3) ? ((k % 97 < 3) ? 1'b0 : 1'b1) : 1'b0;
      ld  = ($urandom_range(0, 5) == 0);
      din = W'($urandom_range(0, 9));
      cycle(e, ld, din);
      check_model($sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
